// File: rtl/swervolf_sw_pkg.sv
// Shared sizing and types for the slide-switch debouncer.
// Holds default width and stable-cycle count plus the switch vector type.
package swervolf_sw_pkg;

    localparam int SW_WIDTH                 = 16;
    localparam int SW_STABLE_CYCLES_DEFAULT = 500000;

    typedef logic [SW_WIDTH-1:0] sw_vec_t;

endpackage

// File: rtl/swervolf_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, registered edge pulses.
// Latency: new level reaches sw_o STABLE_CYCLES+1 edges after capture; no backpressure.
// prime_i forces sw_o to follow the synchroniser and suppresses edge pulses.
module swervolf_debounce_bit
    import swervolf_sw_pkg::*;
#(
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic sw_i,
    input  logic prime_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          sw_q, sw_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sw_d   = sw_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (prime_i) begin
            sw_d = s2_q;
        end else if (s2_q != sw_q) begin
            if (cnt_q == CNT_MAX) begin
                sw_d   = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            sw_q   <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            sw_q   <= sw_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_o   = sw_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/swervolf_sw_debounce.sv
// Debounced slide switches with edge pulses, prime phase and optional sticky IRQ
// (pending/IRQ built only with SWERVOLF_SW_IRQ_EN). Latency STABLE_CYCLES+2 from pin
// to o_sw; o_pending one cycle after the edge pulse; no backpressure.
module swervolf_sw_debounce
    import swervolf_sw_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_primed,
    input  logic [WIDTH-1:0] i_clr,
    output logic [WIDTH-1:0] o_pending,
    output logic             o_irq
);

    localparam int            PW         = $clog2(STABLE_CYCLES + 2);
    localparam logic [PW-1:0] PRIME_LAST = PW'(STABLE_CYCLES + 1);

    logic [PW-1:0] prime_cnt_q, prime_cnt_d;
    logic          primed_q, primed_d;

    // Prime runs STABLE_CYCLES+2 cycles so the synchroniser has settled first.
    always_comb begin
        prime_cnt_d = prime_cnt_q;
        primed_d    = primed_q;
        if (!primed_q) begin
            if (prime_cnt_q == PRIME_LAST) begin
                primed_d = 1'b1;
            end else begin
                prime_cnt_d = prime_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
            primed_q    <= primed_d;
        end
    end

    assign o_primed = primed_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        swervolf_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rstn   (rstn),
            .sw_i   (i_sw[g]),
            .prime_i(~primed_q),
            .sw_o   (o_sw[g]),
            .rise_o (o_rise[g]),
            .fall_o (o_fall[g])
        );
    end

`ifdef SWERVOLF_SW_IRQ_EN
    logic [WIDTH-1:0] pending_q, pending_d;

    // Set has priority over a same-cycle clear.
    always_comb begin
        pending_d = (pending_q & ~i_clr) | o_rise | o_fall;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign o_pending = pending_q;
    assign o_irq     = |pending_q;
`else
    logic unused_clr;
    assign unused_clr = ^i_clr;
    assign o_pending  = '0;
    assign o_irq      = 1'b0;
`endif

endmodule

// File: doc/swervolf_sw_debounce.md
# swervolf_sw_debounce

Debounces and synchronises the Nexys A7 slide switches in the `clk_core` domain. It produces a stable switch vector for the `i_gpio` input of `swervolf_core`, replacing the bare two-flop synchroniser in the board top level. It also produces per-bit edge pulses and a sticky change-pending vector with an interrupt line, so firmware can react to switch changes without polling.

## Interface
- `WIDTH`, default 16: number of switch inputs.
- `STABLE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive cycles a synchronised input must differ from the stable value before it is accepted. Legal range is ≥ 2.
- `clk`  in  1: core clock (`clk_core`).
- `rstn`  in  1: reset. One clock; reset is asynchronous and active-low.
- `i_sw`  in  WIDTH: raw, asynchronous switch pins.
- `o_sw`  out  WIDTH: debounced stable value. Reset value 0.
- `o_rise`  out  WIDTH: one-cycle pulse per bit when `o_sw` goes 0→1. Reset value 0.
- `o_fall`  out  WIDTH: one-cycle pulse per bit when `o_sw` goes 1→0. Reset value 0.
- `o_primed`  out  1: high once the initial load is complete. Reset value 0.
- `i_clr`  in  WIDTH: write-one-to-clear pulses for `o_pending`.
- `o_pending`  out  WIDTH: sticky change flags. Reset value 0.
- `o_irq`  out  1: OR-reduction of `o_pending`. Reset value 0.

## Operation
- **Synchroniser.** Two flops per bit: `s1 <= i_sw`, `s2 <= s1`. Both reset to 0.
- **Per-bit debounce counter.** Width is `$clog2(STABLE_CYCLES)`. Each cycle:
  - if `s2[i] == o_sw[i]`, then `cnt <= 0`;
  - else if `cnt == STABLE_CYCLES-1`, then `o_sw[i] <= s2[i]` and `cnt <= 0`;
  - else `cnt <= cnt+1`.
  - A glitch shorter than `STABLE_CYCLES` cycles resets the count and never reaches `o_sw`.
- **Prime phase.** The prime counter counts from reset for `STABLE_CYCLES+2` cycles.
  - During this phase `o_sw <= s2` every cycle, the per-bit counters are held at 0, and no `o_rise`/`o_fall`/`o_pending` events are generated.
  - This prevents switches already on at reset from producing spurious edges.
  - `o_primed` rises on the cycle after the prime counter terminates and stays high until reset.
- **Edges.** `o_rise[i]` and `o_fall[i]` are registered. They assert in the same cycle the new `o_sw[i]` value first appears, for exactly one cycle.
- **Pending.** `pending[i]` is set by `o_rise[i] | o_fall[i]` and cleared by `i_clr[i]`. If set and clear occur in the same cycle, set wins.
- **Interrupt.** `o_irq = |o_pending`. It is a reduction of flops only, with no combinational path from inputs.
- **Reset mid-operation.** Reset returns all state to reset values, including a new prime phase.

## Timing
- Latency from a clean `i_sw[i]` transition (captured into `s1` at edge k) to `o_sw[i]` updated: edge k+1+`STABLE_CYCLES`. That is `STABLE_CYCLES+2` cycles including the synchroniser.
- `o_rise`/`o_fall` coincide with the `o_sw` update cycle.
- `o_pending` sets one cycle after the edge pulse.
- `o_irq` is valid in the same cycle as `o_pending`.
- `i_clr` takes effect on the next edge.
- An input bouncing with period below `STABLE_CYCLES` holds `o_sw` indefinitely at its last stable value.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.

## Configuration
- **`SWERVOLF_SW_IRQ_EN` defined:** the pending register, `i_clr` handling and `o_irq` are built as described.
- **`SWERVOLF_SW_IRQ_EN` undefined:**
  - `o_pending` and `o_irq` are tied to 0;
  - `i_clr` is ignored;
  - debounce, edge and prime logic are unchanged.

## Structure
- **Package `swervolf_sw_pkg`:** holds `SW_WIDTH` = 16, `SW_STABLE_CYCLES_DEFAULT` = 500000, and the `sw_vec_t` typedef (`logic [SW_WIDTH-1:0]`).
- **Sub-module `swervolf_debounce_bit`:** synchroniser, counter and edge generation for one bit, with a `prime` input. It is instantiated WIDTH times in a generate loop.
- **Parent block:** owns the prime counter and the pending/IRQ logic.

## Test plan
All scenarios use `STABLE_CYCLES` = 8 unless stated.
- **Reset with switches on.** Hold `i_sw`=16'hA5A5 through reset, release `rstn`.
  - `o_primed` rises after 10 cycles.
  - `o_sw`=16'hA5A5.
  - No `o_rise`/`o_fall` pulse; `o_pending`=0 and `o_irq`=0.
- **Clean transition.** After prime, set `i_sw[3]` 0→1.
  - `o_sw[3]` updates exactly 10 cycles after the sampling edge.
  - `o_rise[3]` pulses for 1 cycle; `o_pending`=16'h0008 the following cycle; `o_irq`=1.
- **Bounce rejection.** Toggle `i_sw[0]` every 5 cycles for 100 cycles, then hold 1.
  - `o_sw[0]` stays 0 during the toggling.
  - `o_sw[0]` rises 10 cycles after the final edge, with a single `o_rise[0]`.
- **Clear/set collision.** Assert `i_clr`=16'h0008 in the same cycle `o_fall[3]` pulses.
  - `pending[3]` remains 1.
  - A later `i_clr`=16'h0008 alone clears it; `o_irq` goes 0.
- **Reset mid-count.** Assert `rstn` low 4 cycles into a bit's count.
  - All outputs are 0 immediately (asynchronously).
  - After release, a new 10-cycle prime phase runs with no edge pulses.
- **Build without `SWERVOLF_SW_IRQ_EN`.** Repeat the clean-transition scenario.
  - `o_rise` behaves identically.
  - `o_pending`=0 and `o_irq`=0 throughout.
